// File: rtl/touch_key_pkg.sv
// Shared encodings for the touch-key debounce/selection controller: FSM states,
// key bit positions and the single-key (one-hot) test.
package touch_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam int KEY_TWFI = 0;
    localparam int KEY_FIEI = 1;
    localparam int KEY_EION = 2;

    function automatic logic onehot3(input logic [2:0] v);
        logic [1:0] w_sum;
        w_sum = {1'b0, v[KEY_TWFI]} + {1'b0, v[KEY_FIEI]} + {1'b0, v[KEY_EION]};
        return (w_sum == 2'd1);
    endfunction

endpackage

// File: rtl/touch_sat_cnt.sv
// Saturating frame counter; clr and inc together restart the count at 1.
// Latency 1 clk, no backpressure.
module touch_sat_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q,
    output logic             sat
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= inc ? CNT_W'(1) : '0;
        end else if (inc && !sat) begin
            r_q <= r_q + CNT_W'(1);
        end
    end

    assign q   = r_q;
    assign sat = &r_q;

endmodule

// File: rtl/touch_key_ctrl.sv
// Touch-key debounce and radio-button selection; one press pulse per accepted press.
// Optional auto-repeat while held is enabled by defining TOUCH_KEY_REPEAT_EN.
module touch_key_ctrl
    import touch_key_pkg::*;
#(
    parameter int         DEB_FRAMES    = 4,
    parameter int         REL_FRAMES    = 4,
    parameter int         REPEAT_FRAMES = 30,
    parameter logic [2:0] DEFAULT_SEL   = 3'b001,
    parameter int         CNT_W         = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_stb,
    input  logic [2:0] key_hit,
    output logic [2:0] sel,
    output logic [2:0] press_pulse,
    output logic       busy
);

    localparam logic [CNT_W:0] C_DEB = (CNT_W+1)'(DEB_FRAMES);
    localparam logic [CNT_W:0] C_REL = (CNT_W+1)'(REL_FRAMES);
    localparam logic [CNT_W:0] C_REP = (CNT_W+1)'(REPEAT_FRAMES);

    state_t           r_state;
    logic [2:0]       r_cand;
    logic [2:0]       r_sel;
    logic [2:0]       r_pulse;

    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_sat;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W:0]   w_cnt_p1;
    logic             w_single;
    logic             w_none;
    logic             w_deb_done;
    logic             w_rel_done;
    logic             w_rep_fire;

    assign w_single   = onehot3(key_hit);
    assign w_none     = (key_hit == 3'b000);
    assign w_cnt_p1   = {1'b0, w_cnt} + (CNT_W+1)'(1);
    assign w_deb_done = !w_cnt_sat && (w_cnt_p1 == C_DEB);
    assign w_rel_done = !w_cnt_sat && (w_cnt_p1 == C_REL);

    // Shared debounce/release counter: zeroed on every transition except entry to a counting state.
    always_comb begin
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        if (frame_stb) begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_clr = 1'b1;
                    w_cnt_inc = w_single && (DEB_FRAMES != 1);
                end
                ST_DEBOUNCE: begin
                    if (key_hit == r_cand && !w_deb_done) w_cnt_inc = 1'b1;
                    else                                  w_cnt_clr = 1'b1;
                end
                ST_HELD: begin
                    w_cnt_clr = 1'b1;
                    w_cnt_inc = w_none && (REL_FRAMES != 1);
                end
                ST_RELEASE: begin
                    if (w_none && !w_rel_done) w_cnt_inc = 1'b1;
                    else                       w_cnt_clr = 1'b1;
                end
                default: w_cnt_clr = 1'b1;
            endcase
        end
    end

    touch_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_cnt_inc),
        .q     (w_cnt),
        .sat   (w_cnt_sat)
    );

`ifdef TOUCH_KEY_REPEAT_EN
    logic [CNT_W-1:0] w_rep;
    logic             w_rep_sat;
    logic             w_rep_clr;
    logic             w_rep_inc;
    logic             w_rep_hold;
    logic [CNT_W:0]   w_rep_p1;

    // Any touch (single or multi) keeps a held key alive and counts toward the repeat period.
    assign w_rep_hold = frame_stb && (r_state == ST_HELD) && !w_none;
    assign w_rep_p1   = {1'b0, w_rep} + (CNT_W+1)'(1);
    assign w_rep_fire = w_rep_hold && !w_rep_sat && (w_rep_p1 == C_REP);
    assign w_rep_inc  = w_rep_hold && !w_rep_fire;
    assign w_rep_clr  = frame_stb && !w_rep_inc;

    touch_sat_cnt #(.CNT_W(CNT_W)) u_rep_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_rep_clr),
        .inc   (w_rep_inc),
        .q     (w_rep),
        .sat   (w_rep_sat)
    );
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cand  <= 3'b000;
            r_sel   <= DEFAULT_SEL;
            r_pulse <= 3'b000;
        end else begin
            r_pulse <= 3'b000;
            if (frame_stb) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_single) begin
                            r_cand <= key_hit;
                            if (DEB_FRAMES == 1) begin
                                r_state <= ST_HELD;
                                r_sel   <= key_hit;
                                r_pulse <= key_hit;
                            end else begin
                                r_state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (key_hit == r_cand) begin
                            if (w_deb_done) begin
                                r_state <= ST_HELD;
                                r_sel   <= r_cand;
                                r_pulse <= r_cand;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (w_none) begin
                            r_state <= (REL_FRAMES == 1) ? ST_IDLE : ST_RELEASE;
                        end else if (w_rep_fire) begin
                            r_pulse <= r_cand;
                        end
                    end
                    ST_RELEASE: begin
                        // A touch during release is contact bounce: resume holding, no new pulse.
                        if (!w_none)        r_state <= ST_HELD;
                        else if (w_rel_done) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sel         = r_sel;
    assign press_pulse = r_pulse;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_touch_key_ctrl.sv
// Directed bench for touch_key_ctrl with default parameters; strobes every 8 clks.
module tb_touch_key_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_stb;
    logic [2:0] key_hit;
    logic [2:0] sel;
    logic [2:0] press_pulse;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int base;

    always #5 clk = ~clk;

    touch_key_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_stb   (frame_stb),
        .key_hit     (key_hit),
        .sel         (sel),
        .press_pulse (press_pulse),
        .busy        (busy)
    );

    // Counts clock cycles on which any pulse bit is high, so a stretched pulse counts twice.
    always @(posedge clk) begin
        #1;
        if (press_pulse !== 3'b000) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [2:0] k);
        repeat (7) @(negedge clk);
        key_hit   = k;
        frame_stb = 1'b1;
        @(negedge clk);
        frame_stb = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        frame_stb = 1'b0;
        key_hit   = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sel",   32'(sel), 32'h1);
        chk("rst_pulse", 32'(press_pulse), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);

        // 1: clean press of the middle key
        strobe(3'b010);
        chk("t1_busy_deb", 32'(busy), 32'h1);
        strobe(3'b010);
        strobe(3'b010);
        chk("t1_no_early_pulse", 32'(press_pulse), 32'h0);
        chk("t1_sel_before", 32'(sel), 32'h1);
        strobe(3'b010);
        chk("t1_pulse", 32'(press_pulse), 32'h2);
        chk("t1_sel", 32'(sel), 32'h2);
        chk("t1_busy_held", 32'(busy), 32'h1);
        @(negedge clk);
        chk("t1_pulse_1clk", 32'(press_pulse), 32'h0);
        chk("t1_pulse_cnt", 32'(pulse_cnt), 32'd1);

        // held key survives idle cycles with noisy inputs and no strobe
        for (int i = 0; i < 20; i++) begin
            key_hit = 3'(i);
            @(negedge clk);
        end
        chk("hold_no_stb_busy", 32'(busy), 32'h1);
        strobe(3'b111);
        chk("held_multi_sel", 32'(sel), 32'h2);
        chk("held_multi_busy", 32'(busy), 32'h1);
        repeat (3) strobe(3'b000);
        chk("rel_3_busy", 32'(busy), 32'h1);
        strobe(3'b000);
        chk("rel_4_idle", 32'(busy), 32'h0);

        // 2: bounce during debounce restarts the count
        base = pulse_cnt;
        strobe(3'b100);
        strobe(3'b100);
        strobe(3'b000);
        chk("t2_bounce_idle", 32'(busy), 32'h0);
        repeat (3) strobe(3'b100);
        chk("t2_no_pulse_3", 32'(pulse_cnt - base), 32'd0);
        strobe(3'b100);
        chk("t2_pulse", 32'(press_pulse), 32'h4);
        chk("t2_sel", 32'(sel), 32'h4);

        // 4: release bounce absorbed, no second pulse
        strobe(3'b000);
        strobe(3'b000);
        strobe(3'b010);
        chk("t4_back_held", 32'(busy), 32'h1);
        repeat (3) strobe(3'b000);
        chk("t4_rel_3", 32'(busy), 32'h1);
        strobe(3'b000);
        chk("t4_idle", 32'(busy), 32'h0);
        chk("t4_one_pulse", 32'(pulse_cnt - base), 32'd1);
        chk("t4_sel", 32'(sel), 32'h4);

        // 3: multi-touch and key swap abort debounce
        base = pulse_cnt;
        strobe(3'b001);
        strobe(3'b001);
        strobe(3'b011);
        chk("t3_multi_idle", 32'(busy), 32'h0);
        repeat (3) strobe(3'b001);
        strobe(3'b010);
        chk("t3_swap_idle", 32'(busy), 32'h0);
        strobe(3'b000);
        chk("t3_no_pulse", 32'(pulse_cnt - base), 32'd0);
        chk("t3_sel", 32'(sel), 32'h4);

        // re-press of the selected key pulses again
        repeat (4) strobe(3'b100);
        chk("repress_pulse", 32'(pulse_cnt - base), 32'd1);
        chk("repress_sel", 32'(sel), 32'h4);
        repeat (4) strobe(3'b000);
        chk("repress_idle", 32'(busy), 32'h0);

        // 5: reset mid-debounce discards the press
        base = pulse_cnt;
        repeat (3) strobe(3'b001);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_sel", 32'(sel), 32'h1);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_pulse", 32'(press_pulse), 32'h0);
        for (int i = 0; i < 24; i++) begin
            key_hit = (i % 2 == 0) ? 3'b100 : 3'b001;
            @(negedge clk);
        end
        chk("t5_no_stb_busy", 32'(busy), 32'h0);
        chk("t5_no_pulse", 32'(pulse_cnt - base), 32'd0);
        repeat (3) strobe(3'b100);
        chk("t5_cnt_restart", 32'(pulse_cnt - base), 32'd0);
        strobe(3'b100);
        chk("t5_accept", 32'(press_pulse), 32'h4);
        repeat (4) strobe(3'b000);

        // 6: long hold, with or without auto-repeat
        base = pulse_cnt;
        repeat (64) strobe(3'b100);
        repeat (2) @(negedge clk);
`ifdef TOUCH_KEY_REPEAT_EN
        chk("t6_pulses", 32'(pulse_cnt - base), 32'd3);
`else
        chk("t6_pulses", 32'(pulse_cnt - base), 32'd1);
`endif
        chk("t6_sel", 32'(sel), 32'h4);
        repeat (4) strobe(3'b000);
        chk("t6_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
